// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch time base: a prescaler divides clk to one-second steps that
// drive a four-digit BCD counter. It freezes in HOLD and clears in IDLE.
module stopwatch_time_counter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_count,
    input  logic       enable_pause,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       tick,
    output logic       rollover
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [3:0]    r_sec_ones;
    logic [3:0]    r_sec_tens;
    logic [3:0]    r_min_ones;
    logic [3:0]    r_min_tens;
    logic          r_tick;
    logic          r_rollover;

    logic w_wrap;
    logic w_so_max;
    logic w_st_max;
    logic w_mo_max;
    logic w_mt_max;

    assign w_wrap   = (r_presc == LAST);
    assign w_so_max = (r_sec_ones == 4'd9);
    assign w_st_max = (r_sec_tens == 4'd5);
    assign w_mo_max = (r_min_ones == 4'd9);
    assign w_mt_max = (r_min_tens == 4'd5);

    // enable_pause has priority, so both inputs high behaves as HOLD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (enable_pause) begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end else if (enable_count) begin
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
            if (w_wrap) begin
                r_presc    <= '0;
                r_tick     <= 1'b1;
                r_sec_ones <= w_so_max ? 4'd0 : r_sec_ones + 4'd1;
                if (w_so_max) begin
                    r_sec_tens <= w_st_max ? 4'd0 : r_sec_tens + 4'd1;
                    if (w_st_max) begin
                        r_min_ones <= w_mo_max ? 4'd0 : r_min_ones + 4'd1;
                        if (w_mo_max) begin
                            r_min_tens <= w_mt_max ? 4'd0 : r_min_tens + 4'd1;
                            r_rollover <= w_mt_max;
                        end
                    end
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end else begin
            r_presc    <= '0;
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
            r_tick     <= 1'b0;
            r_rollover <= 1'b0;
        end
    end

    assign sec_ones = r_sec_ones;
    assign sec_tens = r_sec_tens;
    assign min_ones = r_min_ones;
    assign min_tens = r_min_tens;
    assign tick     = r_tick;
    assign rollover = r_rollover;
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed scenarios plus random mode traffic,
// checked every cycle against an elapsed-seconds model.
module tb_stopwatch_time_counter;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_count = 1'b0;
    logic       enable_pause = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       tick, rollover;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Model: elapsed whole seconds plus fractional-second count.
    int m_secs = 0;
    int m_pre  = 0;
    bit m_tick = 1'b0;
    bit m_roll = 1'b0;

    stopwatch_time_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .enable_count(enable_count), .enable_pause(enable_pause),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .tick(tick), .rollover(rollover)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_secs = 0; m_pre = 0; m_tick = 0; m_roll = 0;
        end else if (enable_pause) begin
            m_tick = 0; m_roll = 0;
        end else if (enable_count) begin
            if (m_pre == TD - 1) begin
                m_pre  = 0;
                m_secs = (m_secs + 1) % 3600;
                m_tick = 1;
                m_roll = (m_secs == 0);
            end else begin
                m_pre  = m_pre + 1;
                m_tick = 0;
                m_roll = 0;
            end
        end else begin
            m_secs = 0; m_pre = 0; m_tick = 0; m_roll = 0;
        end
    end

    function automatic logic [15:0] model_bcd();
        int s = m_secs % 60;
        int m = m_secs / 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dut_bcd();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (dut_bcd() !== model_bcd() || tick !== m_tick || rollover !== m_roll) begin
                n_mis++;
                $display("FAIL model t=%0t: got %h tick=%b roll=%b, want %h tick=%b roll=%b",
                         $time, dut_bcd(), tick, rollover, model_bcd(), m_tick, m_roll);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic ec, input logic ep);
        @(negedge clk);
        enable_count = ec;
        enable_pause = ep;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset, release into IDLE
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_digits", dut_bcd(), 16'h0000);
        chk("rst_flags", {14'd0, tick, rollover}, 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            chk("idle_digits", dut_bcd(), 16'h0000);
            chk("idle_tick", {15'd0, tick}, 16'h0);
        end

        // 2: RUN from 00:00
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0);
            chk("run_tick", {15'd0, tick}, (i % 4 == 0) ? 16'h1 : 16'h0);
            if (i == 4)  chk("run_first", dut_bcd(), 16'h0001);
            if (i == 12) chk("run_third", dut_bcd(), 16'h0003);
            if (i == 40) chk("run_carry10", dut_bcd(), 16'h0010);
        end

        // 3: HOLD preserves the fractional second; both-high is HOLD
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step((i >= 5), 1'b1);
            chk("hold_digits", dut_bcd(), 16'h0000);
            chk("hold_tick", {15'd0, tick}, 16'h0);
        end
        step(1'b1, 1'b0);
        chk("resume1_tick", {15'd0, tick}, 16'h0);
        step(1'b1, 1'b0);
        chk("resume2_tick", {15'd0, tick}, 16'h1);
        chk("resume2_digits", dut_bcd(), 16'h0001);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("hold_on_wrap", {15'd0, tick}, 16'h0);
        step(1'b1, 1'b0);
        chk("wrap_after_hold", dut_bcd(), 16'h0002);

        // 5: IDLE clears digits and prescaler
        step(1'b0, 1'b0);
        repeat (38) step(1'b1, 1'b0);
        chk("pre_idle", dut_bcd(), 16'h0009);
        step(1'b0, 1'b0);
        chk("idle_clear", dut_bcd(), 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0);
            chk("reentry_tick", {15'd0, tick}, (i == 4) ? 16'h1 : 16'h0);
        end

        // 4/6: full hour, carry chain and wrap
        step(1'b0, 1'b0);
        for (int i = 1; i <= 3601 * TD; i++) begin
            step(1'b1, 1'b0);
            if (i == 599 * TD)  chk("t_0959", dut_bcd(), 16'h0959);
            if (i == 600 * TD)  chk("t_1000", dut_bcd(), 16'h1000);
            if (i == 3598 * TD) chk("t_5958", dut_bcd(), 16'h5958);
            if (i == 3599 * TD) begin
                chk("t_5959", dut_bcd(), 16'h5959);
                chk("t_5959_roll", {15'd0, rollover}, 16'h0);
            end
            if (i == 3600 * TD) begin
                chk("t_wrap", dut_bcd(), 16'h0000);
                chk("t_wrap_flags", {14'd0, tick, rollover}, 16'h3);
            end
            if (i == 3600 * TD + 1) chk("t_wrap_drop", {14'd0, tick, rollover}, 16'h0);
            if (i == 3601 * TD) begin
                chk("t_0001", dut_bcd(), 16'h0001);
                chk("t_0001_flags", {14'd0, tick, rollover}, 16'h2);
            end
        end

        // Asynchronous reset mid-cycle, just after a tick edge
        #1 reset = 1'b0;
        #1;
        chk("async_digits", dut_bcd(), 16'h0000);
        chk("async_tick", {15'd0, tick}, 16'h0);
        @(negedge clk);
        reset = 1'b1;

        // Random mode traffic with occasional async reset pulses
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 78)      step(1'b1, 1'b0);
            else if (r < 92) step(1'($urandom_range(0, 1)), 1'b1);
            else if (r < 98) step(1'b0, 1'b0);
            else begin
                @(posedge clk);
                #3 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Downstream consumer of the stopwatch control arbiter. It takes the arbiter's enable_count and enable_pause levels and produces the elapsed time as four BCD digits, MM:SS, for the display stage. An internal prescaler divides clk down to one count per second. The time freezes while paused and clears to 00:00 in the idle state.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second increment; must be ≥2; prescaler width = clog2(TICK_DIV).

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable_count  input  1  from arbiter; 1 = counting
enable_pause  input  1  from arbiter; 1 = paused/hold
sec_ones  output  4  BCD seconds units, 0-9
sec_tens  output  4  BCD seconds tens, 0-5
min_ones  output  4  BCD minutes units, 0-9
min_tens  output  4  BCD minutes tens, 0-5
tick  output  1  one-cycle pulse on the edge where the time advanced
rollover  output  1  one-cycle pulse on the edge where 59:59 wrapped to 00:00

Behaviour:
- Reset (reset=0, asynchronous):
  - all digits 0, prescaler 0, tick 0, rollover 0, immediately and regardless of clk.
  - Release is sampled on the next clk edge.
- Mode decode, per cycle:
  - IDLE: enable_count=0, enable_pause=0.
  - RUN: enable_count=1, enable_pause=0.
  - HOLD: enable_pause=1, any enable_count. Both high is illegal from the arbiter and is treated as HOLD.
- IDLE:
  - next edge: prescaler←0, all digits←0, tick←0, rollover←0.
  - Synchronous clear to 00:00.
- HOLD:
  - prescaler and digits keep their values (fractional second preserved); tick←0, rollover←0.
  - Resume continues from the frozen prescaler value.
- RUN:
  - prescaler<TICK_DIV-1: prescaler←prescaler+1, tick←0.
  - prescaler=TICK_DIV-1: prescaler←0, time advances one second, tick←1 on that same edge (registered output).
- Latency:
  - from IDLE, the first edge sampling RUN sets prescaler to 1.
  - the first increment (00:00→00:01, tick high) is registered on the TICK_DIV-th consecutive RUN edge.
- BCD increment chain, all in one edge:
  - sec_ones 9→0 carries to sec_tens.
  - sec_tens 5→0 carries to min_ones.
  - min_ones 9→0 carries to min_tens.
  - min_tens 5→0 is the wrap: 59:59→00:00, rollover←1 together with tick←1. Counting continues after the wrap.
- No digit ever leaves its legal range. Out-of-range values are unreachable; no recovery logic is required.
- Mode changes take effect on the next edge; no extra pipeline stage.
  - RUN→HOLD on the same edge where the prescaler would have wrapped: HOLD wins, no increment, prescaler stays at TICK_DIV-1.
  - On resume, the increment occurs on the first RUN edge.
- Reset asserted mid-count: immediate clear, overriding any mode. tick/rollover drop asynchronously.
- tick and rollover are never high for two consecutive cycles (TICK_DIV≥2).
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
1. TICK_DIV=4. Reset low 3 cycles, then release with IDLE. Digits 00:00, tick=0 throughout. Assert reset mid-cycle and check outputs clear before the next edge.
2. TICK_DIV=4, RUN from 00:00. tick pulses exactly on RUN edges 4, 8, 12. Display reads 00:01, 00:02, 00:03 after each. sec_ones 9→0 with sec_tens 0→1 at the 10th tick.
3. TICK_DIV=4, RUN 2 edges, HOLD 10 edges, RUN again. No change during HOLD. First tick on the 2nd RUN edge after resume, so 4 RUN edges total. Both inputs high behaves identically to HOLD.
4. Force time to 59:58 by running 3598 ticks at TICK_DIV=2. Two more ticks give 59:59, then 00:00 with rollover=1 for exactly one cycle, coincident with tick. The next tick gives 00:01 with rollover=0.
5. Run to 00:09:xx, then drive IDLE for one edge. Digits 00:00 and prescaler 0 on the next edge. Re-entering RUN needs a full 4 edges for the first tick.
6. Boundary carry chain: at 09:59 one tick gives 10:00, all four digits changing in the same cycle, with no intermediate glitch value visible at any edge.
